// File: rtl/riscorvo_dmem_responder.sv
// Memory-side responder for the riscorvo data-memory valid/ready interface.
// Word-addressed SRAM with programmable wait states and out-of-range error reporting.
module riscorvo_dmem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_data_i,
    output logic        ready_data_o,
    input  logic [31:0] addr_data_i,
    input  logic [31:0] write_data_i,
    input  logic        read_write_i,
    input  logic [3:0]  mask_data_i,
    output logic [31:0] read_data_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned AW      = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     mask_q, mask_d;
    logic           rw_q, rw_d;
    logic           oor_q, oor_d;
    logic           ready_q, ready_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           we_s;
    logic           in_range_s;
    logic [31:0]    offset_s;

    logic [31:0]    mem_q [MEM_WORDS];

    // 33-bit compare so the upper bound cannot wrap at the top of the address space
    assign in_range_s = ({1'b0, addr_data_i} >= {1'b0, BASE_ADDR}) &&
                        ({1'b0, addr_data_i} <  LIMIT);
    assign offset_s   = addr_data_i - BASE_ADDR;

    // Next-state, request latching and response generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rw_d    = rw_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_data_i) begin
                    idx_d   = offset_s[AW+1:2];
                    wdata_d = write_data_i;
                    mask_d  = mask_data_i;
                    rw_d    = read_write_i;
                    oor_d   = !in_range_s;
                    cnt_d   = WAIT_LD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!valid_data_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (rw_q) begin
                        we_s = !oor_q;
                    end else begin
                        rdata_d = oor_q ? ERR_RDATA : mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_RESP);
        err_d   = (state_d == ST_RESP) && oor_d;
        busy_d  = (state_d != ST_IDLE);
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0000_0000;
            mask_q  <= 4'h0;
            rw_q    <= 1'b0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rw_q    <= rw_d;
            oor_q   <= oor_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane write into the array, which is deliberately left unreset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_s && mask_q[k]) begin
                mem_q[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign ready_data_o = ready_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign read_data_o  = rdata_q;

endmodule

// File: tb/tb_riscorvo_dmem_responder.sv
// Scoreboard bench for riscorvo_dmem_responder: four instances with wait counts 1, 3, 0 and 15
// share the request bus; each has its own valid and reset.
module tb_riscorvo_dmem_responder;

    localparam int          WC [4]   = '{1, 3, 0, 15};
    localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        valid [4];
    logic        rst_n [4];
    logic        ready [4];
    logic        err   [4];
    logic        busy  [4];
    logic [31:0] rdata [4];
    logic [31:0] addr, wdata;
    logic        rw;
    logic [3:0]  mask;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        riscorvo_dmem_responder #(
            .MEM_WORDS   (1024),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_CYCLES (WC[g]),
            .ERR_RDATA   (ERR_DATA)
        ) u_dut (
            .clk          (clk),
            .reset_n      (rst_n[g]),
            .valid_data_i (valid[g]),
            .ready_data_o (ready[g]),
            .addr_data_i  (addr),
            .write_data_i (wdata),
            .read_write_i (rw),
            .mask_data_i  (mask),
            .read_data_o  (rdata[g]),
            .err_o        (err[g]),
            .busy_o       (busy[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (ready[g] === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_ready_dut%0d", g), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_dut",   32'(g),        32'(e.dut));
                    chk("resp_rdata", rdata[g],      e.rdata);
                    chk("resp_err",   32'(err[g]),   32'(e.err));
                    chk("resp_cycle", 32'(cyc),      32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_ready(input int g, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready[g] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("timeout_dut%0d", g), 32'd0, 32'd1);
            sbq.delete();
        end
    endtask

    // Accepted at edge t: ready is high in the cycle ending at edge t+2+W, seen on the falling edge after edge t+1+W
    task automatic do_req(input int g, input logic rw_i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [31:0] exp_rd, input logic exp_err);
        bit ok;
        @(negedge clk);
        addr = a; wdata = d; rw = rw_i; mask = m; valid[g] = 1'b1;
        @(posedge clk); #1;
        sbq.push_back('{g, exp_rd, exp_err, cyc + 1 + WC[g]});
        wait_ready(g, ok);
        valid[g] = 1'b0;
    endtask

    task automatic read_burst(input int g, input logic [31:0] a [4], input logic [31:0] e [4]);
        bit ok;
        @(negedge clk);
        addr = a[0]; rw = 1'b0; mask = 4'h0; valid[g] = 1'b1;
        @(posedge clk); #1;
        sbq.push_back('{g, e[0], 1'b0, cyc + 1 + WC[g]});
        for (int k = 0; k < 4; k++) begin
            wait_ready(g, ok);
            if (!ok) break;
            if (k < 3) begin
                addr = a[k+1];
                sbq.push_back('{g, e[k+1], 1'b0, cyc + 3 + WC[g]});
            end
        end
        valid[g] = 1'b0;
    endtask

    initial begin
        logic [31:0] ba [4];
        logic [31:0] be [4];
        for (int g = 0; g < 4; g++) begin
            valid[g] = 1'b0;
            rst_n[g] = 1'b0;
        end
        addr = 32'h0; wdata = 32'h0; rw = 1'b0; mask = 4'h0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_ready", 32'(ready[g]), 32'd0);
            chk("rst_err",   32'(err[g]),   32'd0);
            chk("rst_busy",  32'(busy[g]),  32'd0);
            chk("rst_rdata", rdata[g],      32'h0);
        end
        for (int g = 0; g < 4; g++) rst_n[g] = 1'b1;

        // Full write / read, byte-mask merge, zero mask
        do_req(0, 1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 32'h0000_0000, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'hA5A5_5A5A, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'h1122_3344, 4'h5, 32'hA5A5_5A5A, 1'b0);
        do_req(0, 1'b0, 32'h20, 32'h0,         4'h0, 32'hFF22_FF44, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'h0000_0000, 4'h0, 32'hFF22_FF44, 1'b0);
        do_req(0, 1'b0, 32'h20, 32'h0,         4'hF, 32'hFF22_FF44, 1'b0);

        // Range edges; 0x1000 would alias word 0 if the range check were missing
        do_req(0, 1'b1, 32'h0,    32'hCAFE_F00D, 4'hF, 32'hFF22_FF44, 1'b0);
        do_req(0, 1'b1, 32'hFFC,  32'h600D_CAFE, 4'hF, 32'hFF22_FF44, 1'b0);
        do_req(0, 1'b0, 32'hFFF,  32'h0,         4'h0, 32'h600D_CAFE, 1'b0);
        do_req(0, 1'b0, 32'h1000, 32'h0,         4'h0, ERR_DATA,      1'b1);
        do_req(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, ERR_DATA,      1'b1);
        do_req(0, 1'b0, 32'hFFFF_FFFC, 32'h0,    4'h0, ERR_DATA,      1'b1);
        do_req(0, 1'b0, 32'h0,    32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);

        // Valid held across four reads
        ba = '{32'h10, 32'h20, 32'h0, 32'hFFC};
        be = '{32'hA5A5_5A5A, 32'hFF22_FF44, 32'hCAFE_F00D, 32'h600D_CAFE};
        read_burst(0, ba, be);

        // Reset during WAIT of a write
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);
        @(negedge clk);
        addr = 32'h10; wdata = 32'h0BAD_0BAD; rw = 1'b1; mask = 4'hF; valid[0] = 1'b1;
        @(posedge clk); #1;
        chk("busy_in_wait", 32'(busy[0]), 32'd1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready[0]), 32'd0);
        chk("async_rst_busy",  32'(busy[0]),  32'd0);
        chk("async_rst_rdata", rdata[0],      32'h0);
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0);

        // W=3: abort during WAIT leaves array intact and gives no pulse
        do_req(1, 1'b1, 32'h30, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b0);
        @(negedge clk);
        addr = 32'h30; wdata = 32'hDEAD_DEAD; rw = 1'b1; mask = 4'hF; valid[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_busy", 32'(busy[1]), 32'd0);
        do_req(1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

        // W=0 and W=15 latency boundaries
        do_req(2, 1'b1, 32'h44, 32'h0102_0304, 4'hF, 32'h0000_0000, 1'b0);
        do_req(2, 1'b0, 32'h44, 32'h0,         4'h0, 32'h0102_0304, 1'b0);
        do_req(3, 1'b1, 32'h8,  32'h89AB_CDEF, 4'hF, 32'h0000_0000, 1'b0);
        do_req(3, 1'b0, 32'h8,  32'h0,         4'h0, 32'h89AB_CDEF, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
